// File: rtl/wta_pkg.sv
// Shared types for the WTA round scheduler: FSM state encoding and index-width helper.
// No logic; purely declarations.
// No handshake; consumed by the scheduler, its interface and the bench.
package wta_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        SCAN    = 3'd2,
        REPORT  = 3'd3,
        REFRACT = 3'd4
    } state_t;

    // At least one bit so a 2-channel build still has a usable index
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/wta_round_scheduler_if.sv
// Spike/config inputs and winner-record outputs of the WTA round scheduler.
// No logic; master = scheduler side, slave = spike source and record consumer.
// Record uses win_valid/win_ready; inputs are unconditioned.
interface wta_round_scheduler_if
    import wta_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = 6
);
    localparam int ID_W = ch_idx_w(N_CH);

    logic             ena;
    logic [N_CH-1:0]  spike_in;
    logic [7:0]       cfg_window;
    logic [7:0]       cfg_refract;
    logic [CNT_W-1:0] cfg_thresh;
    logic             win_valid;
    logic             win_ready;
    logic [ID_W-1:0]  win_id;
    logic [CNT_W-1:0] win_cnt;
    logic             win_none;
    logic [N_CH-1:0]  inhibit;
    logic             busy;

    modport master (
        input  ena, spike_in, cfg_window, cfg_refract, cfg_thresh, win_ready,
        output win_valid, win_id, win_cnt, win_none, inhibit, busy
    );

    modport slave (
        output ena, spike_in, cfg_window, cfg_refract, cfg_thresh, win_ready,
        input  win_valid, win_id, win_cnt, win_none, inhibit, busy
    );

endinterface

// File: rtl/wta_spike_counter.sv
// One per-channel spike counter: clear, or increment saturating at all-ones.
// Latency 1 cycle; cnt_nxt exposes the value the counter will take this cycle.
// No backpressure; clr has priority over inc.
module wta_spike_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/wta_round_scheduler.sv
// WTA round sequencer: accumulate spikes over a window, scan for the max, report, then inhibit.
// Latency W + N_CH + 1 cycles from the ena-sampling cycle to win_valid (early fire: hit cycle + 2).
// Record held until win_ready; WTA_EARLY_FIRE_EN enables threshold-triggered early reporting.
module wta_round_scheduler
    import wta_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    wta_round_scheduler_if.master bus
);

    localparam int ID_W = ch_idx_w(N_CH);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       timer;
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  best_id;
    logic [CNT_W-1:0] best_cnt;
    logic             cnt_clr;
    logic             in_accum;
    logic             accept;
    logic             scan_done;
    logic             early_hit;
    logic [ID_W-1:0]  early_id;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];

    assign in_accum  = (state == ACCUM);
    assign cnt_clr   = (state == IDLE) || (state == REPORT) || (state == REFRACT);
    assign accept    = (state == REPORT) && bus.win_ready;
    assign scan_done = (scan_idx == ID_W'(N_CH - 1));

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        wta_spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clr     (cnt_clr),
            .inc     (bus.spike_in[g] && in_accum),
            .cnt     (cnt[g]),
            .cnt_nxt (cnt_nxt[g])
        );
    end

`ifdef WTA_EARLY_FIRE_EN
    // Descending walk so the lowest qualifying channel wins
    always_comb begin
        early_hit = 1'b0;
        early_id  = '0;
        if (in_accum && (bus.cfg_thresh != '0)) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (cnt_nxt[i] >= bus.cfg_thresh) begin
                    early_hit = 1'b1;
                    early_id  = ID_W'(i);
                end
            end
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.cfg_thresh;
    assign early_hit     = 1'b0;
    assign early_id      = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ena) state_nxt = ACCUM;
            ACCUM: begin
                if (early_hit)          state_nxt = REPORT;
                else if (timer == 8'd0) state_nxt = SCAN;
            end
            SCAN:    if (scan_done) state_nxt = REPORT;
            REPORT: begin
                if (bus.win_ready) begin
                    if (bus.cfg_refract != 8'd0) state_nxt = REFRACT;
                    else                         state_nxt = bus.ena ? ACCUM : IDLE;
                end
            end
            REFRACT: if (timer == 8'd0) state_nxt = bus.ena ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One timer serves both the accumulate window and the refractory period
    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= 8'd0;
            scan_idx <= '0;
            best_id  <= '0;
            best_cnt <= '0;
        end else begin
            if ((state_nxt == ACCUM) && (state != ACCUM)) begin
                timer <= (bus.cfg_window == 8'd0) ? 8'd0 : bus.cfg_window - 8'd1;
            end else if (accept) begin
                timer <= bus.cfg_refract - 8'd1;
            end else if (timer != 8'd0) begin
                timer <= timer - 8'd1;
            end

            if (in_accum && early_hit) begin
                best_id  <= early_id;
                best_cnt <= cnt_nxt[early_id];
            end else if (in_accum && (state_nxt == SCAN)) begin
                scan_idx <= '0;
                best_id  <= '0;
                best_cnt <= '0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + ID_W'(1);
                if (cnt[scan_idx] > best_cnt) begin
                    best_id  <= scan_idx;
                    best_cnt <= cnt[scan_idx];
                end
            end
        end
    end

    always_comb begin
        bus.win_valid = (state == REPORT);
        bus.win_id    = best_id;
        bus.win_cnt   = best_cnt;
        bus.win_none  = (state == REPORT) && (best_cnt == '0);
        bus.busy      = (state != IDLE);
        bus.inhibit   = '0;
        if ((state == REFRACT) && (best_cnt != '0)) begin
            bus.inhibit = N_CH'(1) << best_id;
        end
    end

endmodule

// File: tb/tb_wta_round_scheduler.sv
// Randomized and directed bench for wta_round_scheduler against a count/argmax reference model.
module tb_wta_round_scheduler;

    localparam int N_CH  = 8;
    localparam int CNT_W = 6;
    localparam int ID_W  = 3;
    localparam int CMAX  = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wta_round_scheduler_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();
    wta_round_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [N_CH-1:0] stim [256];
    int  thr;
    int  exp_id, exp_cnt, exp_lat;
    bit  exp_none;
    int  obs_lat;

    // Reference: per-channel totals clipped at CMAX, winner = first index holding the maximum
    task automatic model(input int weff);
        int cnt [N_CH];
        int mx;
        foreach (cnt[i]) cnt[i] = 0;
        exp_lat = weff + N_CH + 1;
        for (int j = 0; j < weff; j++) begin
            for (int i = 0; i < N_CH; i++)
                if (stim[j][i]) cnt[i] = (cnt[i] >= CMAX) ? CMAX : cnt[i] + 1;
`ifdef WTA_EARLY_FIRE_EN
            if (thr != 0) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (cnt[i] >= thr) begin
                        exp_id = i; exp_cnt = cnt[i]; exp_none = 1'b0; exp_lat = j + 2;
                        return;
                    end
                end
            end
`endif
        end
        mx = 0;
        foreach (cnt[i]) if (cnt[i] > mx) mx = cnt[i];
        exp_cnt = mx; exp_none = (mx == 0); exp_id = 0;
        for (int i = N_CH - 1; i >= 0; i--) if (cnt[i] == mx) exp_id = i;
    endtask

    task automatic clear_stim();
        foreach (stim[j]) stim[j] = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; bus.ena = 1'b0; bus.win_ready = 1'b0; bus.spike_in = '0;
        bus.cfg_window = 8'd1; bus.cfg_refract = 8'd0; bus.cfg_thresh = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Start one round from IDLE and wait (bounded) for win_valid; spikes outside the window are junk
    task automatic run_round(input int win, input int refr);
        int weff;
        weff = (win == 0) ? 1 : win;
        bus.cfg_window = 8'(win); bus.cfg_refract = 8'(refr); bus.cfg_thresh = CNT_W'(thr);
        bus.ena = 1'b1; bus.win_ready = 1'b0; bus.spike_in = N_CH'($urandom);
        obs_lat = 0;
        while (!bus.win_valid && obs_lat < 700) begin
            @(posedge clk); #1;
            obs_lat++;
            bus.ena = 1'b0;
            bus.spike_in = (obs_lat - 1 < weff) ? stim[obs_lat - 1] : N_CH'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ena = 1'b1; bus.win_ready = 1'b1;
        bus.cfg_window = 8'd3; bus.cfg_refract = 8'd2; bus.cfg_thresh = '0;
        for (int c = 0; c < 2; c++) begin
            bus.spike_in = (c == 0) ? 8'hA5 : 8'h5A;
            @(posedge clk); #1;
        end
        n_tests++;
        if ({bus.win_valid, bus.win_id, bus.win_cnt, bus.win_none, bus.inhibit, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b id=%0d cnt=%0d none=%0b inh=%h busy=%0b, expected all 0",
                     bus.win_valid, bus.win_id, bus.win_cnt, bus.win_none, bus.inhibit, bus.busy);
        end
        rst = 1'b0; bus.ena = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got busy=%0b valid=%0b, expected 0 0", bus.busy, bus.win_valid);
        end
        bus.win_ready = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset(); clear_stim(); thr = 0;
        for (int j = 0; j < 7; j++) stim[j][3] = 1'b1;
        for (int j = 2; j < 6; j++) stim[j][5] = 1'b1;
        run_round(10, 0);
        n_tests++;
        if (obs_lat !== 19 || bus.win_id !== 3'd3 || bus.win_cnt !== 6'd7 || bus.win_none !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_round: got lat=%0d id=%0d cnt=%0d none=%0b, expected lat=19 id=3 cnt=7 none=0",
                     obs_lat, bus.win_id, bus.win_cnt, bus.win_none);
        end
        bus.win_ready = 1'b1;
        @(posedge clk); #1;
        bus.win_ready = 1'b0;
        n_tests++;
        if (bus.win_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: got valid=%0b busy=%0b, expected 0 0", bus.win_valid, bus.busy);
        end
    endtask

    task automatic test_tie_none();
        apply_reset(); clear_stim(); thr = 0;
        for (int j = 0; j < 5; j++) begin stim[j][2] = 1'b1; stim[j + 3][6] = 1'b1; end
        run_round(8, 0);
        n_tests++;
        if (bus.win_id !== 3'd2 || bus.win_cnt !== 6'd5) begin
            n_fail++;
            $display("FAIL tie_low_index: got id=%0d cnt=%0d, expected id=2 cnt=5", bus.win_id, bus.win_cnt);
        end
        bus.win_ready = 1'b1; @(posedge clk); #1; bus.win_ready = 1'b0;

        clear_stim();
        run_round(6, 3);
        n_tests++;
        if (bus.win_none !== 1'b1 || bus.win_id !== 3'd0 || bus.win_cnt !== 6'd0 || obs_lat !== 15) begin
            n_fail++;
            $display("FAIL none_record: got none=%0b id=%0d cnt=%0d lat=%0d, expected none=1 id=0 cnt=0 lat=15",
                     bus.win_none, bus.win_id, bus.win_cnt, obs_lat);
        end
        bus.win_ready = 1'b1; @(posedge clk); #1; bus.win_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.inhibit !== 8'h00 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL none_refract_c%0d: got inh=%h busy=%0b, expected 00 1", c, bus.inhibit, bus.busy);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL none_refract_end: got busy=%0b, expected 0", bus.busy);
        end
    endtask

    task automatic test_saturation();
        apply_reset(); clear_stim(); thr = 0;
        for (int j = 0; j < 100; j++) stim[j] = {1'b0, 6'($urandom_range(0, 63) & 6'h15), 1'b1};
        model(100);
        run_round(100, 0);
        n_tests++;
        if (bus.win_cnt !== 6'd63 || bus.win_id !== 3'd0 || obs_lat !== exp_lat) begin
            n_fail++;
            $display("FAIL saturation: got cnt=%0d id=%0d lat=%0d, expected cnt=63 id=0 lat=%0d",
                     bus.win_cnt, bus.win_id, obs_lat, exp_lat);
        end
        bus.win_ready = 1'b1; @(posedge clk); #1; bus.win_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic       stable;
        logic [2:0] id0;
        logic [5:0] cnt0;
        int         accepts;
        apply_reset(); clear_stim(); thr = 0;
        for (int j = 0; j < 3; j++) stim[j][3] = 1'b1;
        stim[1][6] = 1'b1;
        run_round(5, 4);
        id0 = bus.win_id; cnt0 = bus.win_cnt; stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (!bus.win_valid || bus.win_id !== id0 || bus.win_cnt !== cnt0) stable = 1'b0;
        end
        n_tests++;
        if (stable !== 1'b1 || id0 !== 3'd3 || cnt0 !== 6'd3) begin
            n_fail++;
            $display("FAIL bp_hold: got stable=%0b id=%0d cnt=%0d, expected stable=1 id=3 cnt=3", stable, id0, cnt0);
        end
        bus.win_ready = 1'b1; @(posedge clk); #1;
        accepts = 0; stable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.win_valid) accepts++;
            if (bus.inhibit !== 8'h08) stable = 1'b0;
            @(posedge clk); #1;
        end
        bus.win_ready = 1'b0;
        n_tests++;
        if (accepts !== 0 || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_refract: got extra_valid=%0d inhibit_ok=%0b, expected 0 1", accepts, stable);
        end
        n_tests++;
        if (bus.inhibit !== 8'h00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_refract_end: got inh=%h busy=%0b, expected 00 0", bus.inhibit, bus.busy);
        end
    endtask

    task automatic test_random();
        int win, refr, weff;
        logic [N_CH-1:0] mask;
        logic ok;
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            win  = (r == 0) ? 0 : $urandom_range(1, 24);
            refr = $urandom_range(0, 3);
            thr  = $urandom_range(0, 6);
            weff = (win == 0) ? 1 : win;
            clear_stim();
            for (int j = 0; j < weff; j++) stim[j] = N_CH'($urandom) & N_CH'($urandom);
            model(weff);
            run_round(win, refr);
            n_tests++;
            if (obs_lat !== exp_lat || bus.win_id !== ID_W'(exp_id) || bus.win_cnt !== CNT_W'(exp_cnt)
                || bus.win_none !== exp_none) begin
                n_fail++;
                $display("FAIL random_r%0d: got lat=%0d id=%0d cnt=%0d none=%0b, expected lat=%0d id=%0d cnt=%0d none=%0b",
                         r, obs_lat, bus.win_id, bus.win_cnt, bus.win_none, exp_lat, exp_id, exp_cnt, exp_none);
            end
            mask = '0;
            if (!exp_none) mask[exp_id] = 1'b1;
            bus.win_ready = 1'b1; @(posedge clk); #1; bus.win_ready = 1'b0;
            ok = !bus.win_valid;
            for (int c = 0; c < refr; c++) begin
                if (bus.inhibit !== mask) ok = 1'b0;
                @(posedge clk); #1;
            end
            if (bus.busy !== 1'b0 || bus.inhibit !== '0) ok = 1'b0;
            n_tests++;
            if (ok !== 1'b1) begin
                n_fail++;
                $display("FAIL random_refract_r%0d: got inh=%h busy=%0b after %0d cycles, expected mask %h then idle",
                         r, bus.inhibit, bus.busy, refr, mask);
            end
        end
    endtask

    task automatic test_rst_mid_accum();
        apply_reset(); clear_stim(); thr = 0;
        bus.cfg_window = 8'd50; bus.cfg_refract = 8'd2; bus.ena = 1'b1; bus.spike_in = 8'hFF;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.win_valid !== 1'b0 || bus.win_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_mid_accum: got busy=%0b valid=%0b cnt=%0d, expected 0 0 0", bus.busy, bus.win_valid, bus.win_cnt);
        end
        rst = 1'b0; bus.ena = 1'b0; bus.spike_in = '0;
        // Counts from the aborted round must not leak into the next one
        stim[0][4] = 1'b1; stim[1][4] = 1'b1;
        run_round(2, 0);
        n_tests++;
        if (bus.win_id !== 3'd4 || bus.win_cnt !== 6'd2 || obs_lat !== 11) begin
            n_fail++;
            $display("FAIL rst_fresh_round: got id=%0d cnt=%0d lat=%0d, expected id=4 cnt=2 lat=11",
                     bus.win_id, bus.win_cnt, obs_lat);
        end
        bus.win_ready = 1'b1; @(posedge clk); #1; bus.win_ready = 1'b0;
    endtask

    task automatic test_early_fire();
        apply_reset(); clear_stim(); thr = 3;
        for (int j = 0; j < 3; j++) stim[j][1] = 1'b1;
        model(20);
        run_round(20, 0);
        n_tests++;
        if (obs_lat !== exp_lat || bus.win_id !== 3'd1 || bus.win_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL early_fire: got lat=%0d id=%0d cnt=%0d, expected lat=%0d id=1 cnt=3",
                     obs_lat, bus.win_id, bus.win_cnt, exp_lat);
        end
`ifdef WTA_EARLY_FIRE_EN
        n_tests++;
        if (obs_lat !== 4) begin
            n_fail++;
            $display("FAIL early_fire_latency: got %0d, expected 4", obs_lat);
        end
`endif
        bus.win_ready = 1'b1; @(posedge clk); #1; bus.win_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; thr = 0;
        bus.ena = 1'b0; bus.win_ready = 1'b0; bus.spike_in = '0;
        bus.cfg_window = 8'd1; bus.cfg_refract = 8'd0; bus.cfg_thresh = '0;
        #1;
        test_reset();
        test_basic();
        test_tie_none();
        test_saturation();
        test_backpressure();
        test_random();
        test_rst_mid_accum();
        test_early_fire();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
